// File: rtl/spi_target_model.sv
// SPI mode-0 target emulating a small byte-addressed memory device.
// Pins are oversampled on clk_in; commands: 0x02 write, 0x03 read, 0x9F ID.
// Host read port and write-event strobes expose the traffic to FPGA logic.
module spi_target_model #(
   parameter int         DEPTH   = 256,
   parameter logic [7:0] ID_BYTE = 8'hA5
) (
   input  logic                     clk_in,
   input  logic                     reset,
   input  logic                     spi_sck,
   input  logic                     spi_csn,
   input  logic                     spi_mosi,
   output logic                     spi_miso,
   output logic                     spi_miso_oe,
   input  logic [$clog2(DEPTH)-1:0] host_addr,
   output logic [7:0]               host_rdata,
   output logic                     wr_strobe,
   output logic [$clog2(DEPTH)-1:0] wr_addr,
   output logic [7:0]               wr_data,
   output logic                     bad_cmd,
   output logic                     active
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE, S_CMD, S_ADDR_HI, S_ADDR_LO, S_WRITE, S_READ, S_ID, S_IGNORE
   } state_t;

   logic          sck_s1_q, sck_s2_q, sck_s3_q;
   logic          csn_s1_q, csn_s2_q, csn_s3_q;
   logic          mosi_s1_q, mosi_s2_q, mosi_s3_q;
   logic          sck_rise_q, sck_fall_q, csn_fall_q, csn_rise_q;
   logic [1:0]    settle_q;
   logic          armed_q;

   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q;
   logic [6:0]    rx_q;
   logic [7:0]    tx_q;
   logic [7:0]    addr_hi_q;
   logic [AW-1:0] addr_q;
   logic          op_wr_q;
   logic          miso_q;
   logic          wr_strobe_q;
   logic [AW-1:0] wr_addr_q;
   logic [7:0]    wr_data_q;
   logic          bad_cmd_q;
   logic [7:0]    host_rdata_q;
   logic [7:0]    mem_q [DEPTH];

   logic [7:0]    rx_byte;
   logic          byte_done;
   logic [AW-1:0] addr_start;

   // rx_byte is the byte as it stands including the bit sampled on this rise
   assign rx_byte    = {rx_q, mosi_s3_q};
   assign byte_done  = sck_rise_q & (bit_cnt_q == 3'd7) & (state_q != S_IDLE) & ~csn_rise_q;
   assign addr_start = AW'({addr_hi_q, rx_byte});

   // Two-flop synchronizers, one extra stage for edge detect, registered events.
   // After reset a CSN fall is only honoured once CSN has been seen high, so a
   // transaction interrupted by reset is not resumed.
   always_ff @(posedge clk_in) begin
      if (reset) begin
         sck_s1_q   <= 1'b0;  sck_s2_q  <= 1'b0;  sck_s3_q  <= 1'b0;
         csn_s1_q   <= 1'b1;  csn_s2_q  <= 1'b1;  csn_s3_q  <= 1'b1;
         mosi_s1_q  <= 1'b0;  mosi_s2_q <= 1'b0;  mosi_s3_q <= 1'b0;
         sck_rise_q <= 1'b0;  sck_fall_q <= 1'b0;
         csn_fall_q <= 1'b0;  csn_rise_q <= 1'b0;
         settle_q   <= 2'd0;
         armed_q    <= 1'b0;
      end else begin
         sck_s1_q   <= spi_sck;   sck_s2_q  <= sck_s1_q;  sck_s3_q  <= sck_s2_q;
         csn_s1_q   <= spi_csn;   csn_s2_q  <= csn_s1_q;  csn_s3_q  <= csn_s2_q;
         mosi_s1_q  <= spi_mosi;  mosi_s2_q <= mosi_s1_q; mosi_s3_q <= mosi_s2_q;
         sck_rise_q <= sck_s2_q & ~sck_s3_q;
         sck_fall_q <= ~sck_s2_q & sck_s3_q;
         csn_fall_q <= armed_q & ~csn_s2_q & csn_s3_q;
         csn_rise_q <= csn_s2_q & ~csn_s3_q;
         if (settle_q != 2'd3) settle_q <= settle_q + 2'd1;
         else if (csn_s2_q)    armed_q  <= 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk_in) begin
      if (reset) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; a CSN rise wins over everything else
   always_comb begin
      state_d = state_q;
      if (csn_rise_q) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:    if (csn_fall_q) state_d = S_CMD;
            S_CMD:     if (byte_done) begin
                          if (rx_byte == 8'h02 || rx_byte == 8'h03) state_d = S_ADDR_HI;
                          else if (rx_byte == 8'h9F)                state_d = S_ID;
                          else                                      state_d = S_IGNORE;
                       end
            S_ADDR_HI: if (byte_done) state_d = S_ADDR_LO;
            S_ADDR_LO: if (byte_done) state_d = op_wr_q ? S_WRITE : S_READ;
            default:   state_d = state_q;
         endcase
      end
   end

   // FSM outputs: MISO is driven only in a read or ID data phase
   always_comb begin
      spi_miso_oe = 1'b0;
      spi_miso    = 1'b0;
      if (state_q == S_READ || state_q == S_ID) begin
         spi_miso_oe = 1'b1;
         spi_miso    = miso_q;
      end
   end

   // Bit/byte handling, address tracking, transmit shifter and event pulses
   always_ff @(posedge clk_in) begin
      if (reset) begin
         bit_cnt_q   <= 3'd0;
         rx_q        <= 7'd0;
         tx_q        <= 8'd0;
         addr_hi_q   <= 8'd0;
         addr_q      <= '0;
         op_wr_q     <= 1'b0;
         miso_q      <= 1'b0;
         wr_strobe_q <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 8'd0;
         bad_cmd_q   <= 1'b0;
      end else begin
         wr_strobe_q <= 1'b0;
         bad_cmd_q   <= 1'b0;
         if (state_q == S_IDLE) begin
            bit_cnt_q <= 3'd0;
         end else if (sck_rise_q) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            rx_q      <= rx_byte[6:0];
         end
         if (sck_fall_q) begin
            miso_q <= tx_q[7];
            tx_q   <= {tx_q[6:0], 1'b0};
         end
         if (byte_done) begin
            case (state_q)
               S_CMD: begin
                  op_wr_q <= (rx_byte == 8'h02);
                  if (rx_byte == 8'h9F) tx_q <= ID_BYTE;
                  else if (rx_byte != 8'h02 && rx_byte != 8'h03) bad_cmd_q <= 1'b1;
               end
               S_ADDR_HI: addr_hi_q <= rx_byte;
               S_ADDR_LO: begin
                  if (op_wr_q) begin
                     addr_q <= addr_start;
                  end else begin
                     tx_q   <= mem_q[addr_start];
                     addr_q <= addr_start + AW'(1);
                  end
               end
               S_WRITE: begin
                  wr_strobe_q <= 1'b1;
                  wr_addr_q   <= addr_q;
                  wr_data_q   <= rx_byte;
                  addr_q      <= addr_q + AW'(1);
               end
               S_READ: begin
                  tx_q   <= mem_q[addr_q];
                  addr_q <= addr_q + AW'(1);
               end
               S_ID:    tx_q <= ID_BYTE;
               default: ;
            endcase
         end
      end
   end

   // Memory commit happens on the strobe cycle, so a same-cycle host read sees old data
   always_ff @(posedge clk_in) begin
      if (wr_strobe_q) mem_q[wr_addr_q] <= wr_data_q;
   end

   // Registered host read port
   always_ff @(posedge clk_in) begin
      if (reset) host_rdata_q <= 8'd0;
      else       host_rdata_q <= mem_q[host_addr];
   end

   assign host_rdata = host_rdata_q;
   assign wr_strobe  = wr_strobe_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign bad_cmd    = bad_cmd_q;
   assign active     = ~csn_s2_q;

endmodule

// File: tb/tb_spi_target_model.sv
// Self-checking bench for spi_target_model: drives SPI mode-0 transactions
// and compares against a transaction-level memory model.
module tb_spi_target_model;

   localparam int         DEPTH = 256;
   localparam int         AW    = 8;
   localparam logic [7:0] ID    = 8'hA5;

   logic          clk_in = 1'b0;
   logic          reset;
   logic          spi_sck, spi_csn, spi_mosi;
   logic          spi_miso, spi_miso_oe;
   logic [AW-1:0] host_addr;
   logic [7:0]    host_rdata;
   logic          wr_strobe;
   logic [AW-1:0] wr_addr;
   logic [7:0]    wr_data;
   logic          bad_cmd;
   logic          active;

   spi_target_model #(.DEPTH(DEPTH), .ID_BYTE(ID)) dut (
      .clk_in(clk_in), .reset(reset),
      .spi_sck(spi_sck), .spi_csn(spi_csn), .spi_mosi(spi_mosi),
      .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
      .host_addr(host_addr), .host_rdata(host_rdata),
      .wr_strobe(wr_strobe), .wr_addr(wr_addr), .wr_data(wr_data),
      .bad_cmd(bad_cmd), .active(active)
   );

   always #5 clk_in = ~clk_in;

   int checks   = 0;
   int failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: byte memory plus "known" flags (uninitialised = don't care)
   logic [7:0] ref_mem [DEPTH];
   bit         ref_ok  [DEPTH];

   // Observed write events and bad_cmd activity, recorded away from the active edge
   logic [AW-1:0] obs_addr [1024];
   logic [7:0]    obs_data [1024];
   int            obs_cnt    = 0;
   int            bad_pulses = 0;
   int            bad_hi     = 0;
   logic          bad_prev   = 1'b0;

   always @(negedge clk_in) begin
      if (wr_strobe) begin
         if (obs_cnt < 1024) begin
            obs_addr[obs_cnt] = wr_addr;
            obs_data[obs_cnt] = wr_data;
         end
         obs_cnt++;
      end
      if (bad_cmd) bad_hi++;
      if (bad_cmd && !bad_prev) bad_pulses++;
      bad_prev = bad_cmd;
   end

   initial begin
      #900000;
      $display("FAIL watchdog got=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   int         half = 4;
   logic [7:0] tx_buf [64];
   logic [7:0] rx_buf [64];
   int         oe_buf [64];

   task automatic spi_bits(input logic [7:0] b, input int nbits, output logic [7:0] r, output int oe_n);
      r    = 8'd0;
      oe_n = 0;
      for (int i = 0; i < nbits; i++) begin
         @(negedge clk_in);
         spi_mosi = b[7-i];
         repeat (half - 1) @(negedge clk_in);
         r = {r[6:0], spi_miso};
         if (spi_miso_oe) oe_n++;
         spi_sck = 1'b1;
         repeat (half) @(negedge clk_in);
         spi_sck = 1'b0;
      end
   endtask

   task automatic spi_txn(input int nbytes);
      @(negedge clk_in);
      spi_csn = 1'b0;
      repeat (4) @(negedge clk_in);
      for (int k = 0; k < nbytes; k++) spi_bits(tx_buf[k], 8, rx_buf[k], oe_buf[k]);
      repeat (4) @(negedge clk_in);
      spi_csn = 1'b1;
      repeat (8) @(negedge clk_in);
   endtask

   // Run one framed transaction and check it against the model
   task automatic do_txn(input int nbytes, input string tag);
      int         w0, bp0, bh0, base, nw, a, eo, exp_bad;
      logic [7:0] cmd, er;
      bit         known;
      w0  = obs_cnt;
      bp0 = bad_pulses;
      bh0 = bad_hi;
      spi_txn(nbytes);
      cmd  = tx_buf[0];
      base = (int'(tx_buf[1]) * 256 + int'(tx_buf[2])) % DEPTH;
      for (int k = 0; k < nbytes; k++) begin
         er = 8'd0; eo = 0; known = 1'b1;
         if (cmd == 8'h9F && k >= 1) begin
            er = ID; eo = 8;
         end else if (cmd == 8'h03 && k >= 3) begin
            a = (base + k - 3) % DEPTH;
            er = ref_mem[a]; eo = 8; known = ref_ok[a];
         end
         if (known) check_eq($sformatf("%s_rx%0d", tag, k), 32'(rx_buf[k]), 32'(er));
         check_eq($sformatf("%s_oe%0d", tag, k), 32'(oe_buf[k]), 32'(eo));
      end
      nw = (cmd == 8'h02 && nbytes > 3) ? nbytes - 3 : 0;
      check_eq({tag, "_wrcnt"}, 32'(obs_cnt - w0), 32'(nw));
      for (int i = 0; i < nw && w0 + i < obs_cnt; i++) begin
         a = (base + i) % DEPTH;
         check_eq($sformatf("%s_wa%0d", tag, i), 32'(obs_addr[w0+i]), 32'(a));
         check_eq($sformatf("%s_wd%0d", tag, i), 32'(obs_data[w0+i]), 32'(tx_buf[3+i]));
      end
      for (int i = 0; i < nw; i++) begin
         a = (base + i) % DEPTH;
         ref_mem[a] = tx_buf[3+i];
         ref_ok[a]  = 1'b1;
      end
      exp_bad = (cmd != 8'h02 && cmd != 8'h03 && cmd != 8'h9F) ? 1 : 0;
      check_eq({tag, "_badpulse"}, 32'(bad_pulses - bp0), 32'(exp_bad));
      check_eq({tag, "_badwidth"}, 32'(bad_hi - bh0), 32'(exp_bad));
   endtask

   task automatic host_chk(input int a, input string tag);
      @(negedge clk_in);
      host_addr = AW'(a);
      @(negedge clk_in);
      check_eq(tag, 32'(host_rdata), 32'(ref_mem[a]));
   endtask

   task automatic check_idle_outputs(input string tag);
      check_eq({tag, "_miso"},  32'(spi_miso),    32'd0);
      check_eq({tag, "_oe"},    32'(spi_miso_oe), 32'd0);
      check_eq({tag, "_rdata"}, 32'(host_rdata),  32'd0);
      check_eq({tag, "_wstb"},  32'(wr_strobe),   32'd0);
      check_eq({tag, "_waddr"}, 32'(wr_addr),     32'd0);
      check_eq({tag, "_wdata"}, 32'(wr_data),     32'd0);
      check_eq({tag, "_bad"},   32'(bad_cmd),     32'd0);
      check_eq({tag, "_act"},   32'(active),      32'd0);
   endtask

   initial begin
      logic [7:0] r;
      int         oe_n, n, base, w0;
      reset = 1'b1; spi_sck = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0; host_addr = '0;
      for (int i = 0; i < DEPTH; i++) begin ref_mem[i] = 8'd0; ref_ok[i] = 1'b0; end

      // Reset state
      repeat (3) @(negedge clk_in);
      check_idle_outputs("reset");
      reset = 1'b0;
      repeat (6) @(negedge clk_in);

      // Write burst 02 00 10 11 22 33, host read of 0x11
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h10;
      tx_buf[3] = 8'h11; tx_buf[4] = 8'h22; tx_buf[5] = 8'h33;
      do_txn(6, "wr_burst");
      host_chk(8'h11, "host_0x11");

      // Read burst of the same three bytes
      tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h10;
      tx_buf[3] = 8'h00; tx_buf[4] = 8'h00; tx_buf[5] = 8'h00;
      do_txn(6, "rd_burst");

      // Write wrap at 0x00FF, then ID
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'hFF; tx_buf[3] = 8'hAB; tx_buf[4] = 8'hCD;
      do_txn(5, "wr_wrap");
      host_chk(8'hFF, "host_0xff");
      host_chk(8'h00, "host_0x00");
      tx_buf[0] = 8'h9F; tx_buf[1] = 8'h12; tx_buf[2] = 8'h34;
      do_txn(3, "id");

      // Bad command and address aliasing
      tx_buf[0] = 8'h55; tx_buf[1] = 8'hFF; tx_buf[2] = 8'hFF; tx_buf[3] = 8'hFF;
      do_txn(4, "badcmd");
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h12; tx_buf[2] = 8'h34; tx_buf[3] = 8'h77;
      do_txn(4, "alias");

      // Same-cycle host read returns old data, new data one cycle later
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h40; tx_buf[3] = 8'h5A;
      do_txn(4, "pre40");
      @(negedge clk_in);
      host_addr = 8'h40;
      tx_buf[3] = 8'hC3;
      fork
         do_txn(4, "wr40");
         begin
            n = 0;
            while (!wr_strobe && n < 5000) begin @(negedge clk_in); n++; end
            if (!wr_strobe) check_eq("commit_wait", 32'd0, 32'd1);
            else begin
               @(negedge clk_in);
               check_eq("commit_old", 32'(host_rdata), 32'h5A);
               @(negedge clk_in);
               check_eq("commit_new", 32'(host_rdata), 32'hC3);
            end
         end
      join

      // Abort after 5 bits of a write data byte
      tx_buf[0] = 8'h02; tx_buf[1] = 8'h00; tx_buf[2] = 8'h20; tx_buf[3] = 8'h96;
      do_txn(4, "pre20");
      w0 = obs_cnt;
      @(negedge clk_in);
      spi_csn = 1'b0;
      repeat (4) @(negedge clk_in);
      spi_bits(8'h02, 8, r, oe_n);
      spi_bits(8'h00, 8, r, oe_n);
      spi_bits(8'h20, 8, r, oe_n);
      spi_bits(8'h3C, 5, r, oe_n);
      repeat (4) @(negedge clk_in);
      spi_csn = 1'b1;
      repeat (12) @(negedge clk_in);
      check_eq("abort_wrcnt", 32'(obs_cnt - w0), 32'd0);
      check_eq("abort_active", 32'(active), 32'd0);
      tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h20; tx_buf[3] = 8'h00;
      do_txn(4, "abort_rd");

      // Reset mid-read
      @(negedge clk_in);
      spi_csn = 1'b0;
      repeat (4) @(negedge clk_in);
      spi_bits(8'h03, 8, r, oe_n);
      spi_bits(8'h00, 8, r, oe_n);
      spi_bits(8'h10, 8, r, oe_n);
      spi_bits(8'h00, 3, r, oe_n);
      reset = 1'b1;
      @(negedge clk_in);
      check_idle_outputs("midrst");
      reset = 1'b0;
      spi_bits(8'h00, 8, r, oe_n);
      check_eq("midrst_oe_a", 32'(oe_n), 32'd0);
      check_eq("midrst_rx_a", 32'(r), 32'd0);
      spi_bits(8'h00, 8, r, oe_n);
      check_eq("midrst_oe_b", 32'(oe_n), 32'd0);
      repeat (4) @(negedge clk_in);
      spi_csn = 1'b1;
      repeat (10) @(negedge clk_in);
      tx_buf[0] = 8'h03; tx_buf[1] = 8'h00; tx_buf[2] = 8'h10;
      tx_buf[3] = 8'h00; tx_buf[4] = 8'h00; tx_buf[5] = 8'h00;
      do_txn(6, "post_rst_rd");

      // Randomized transactions with random SCK half-periods
      for (int t = 0; t < 8; t++) begin
         half = int'($urandom_range(4, 6));
         case ($urandom_range(0, 3))
            0:       tx_buf[0] = 8'h02;
            1:       tx_buf[0] = 8'h03;
            2:       tx_buf[0] = 8'h9F;
            default: tx_buf[0] = 8'($urandom);
         endcase
         for (int k = 1; k < 12; k++) tx_buf[k] = 8'($urandom);
         n = int'($urandom_range(1, 11));
         do_txn(n, $sformatf("rnd%0d", t));
      end

      // Timing margin: 32-byte write, then 32-byte read at minimum half-period
      half = int'($urandom_range(4, 6));
      base = int'($urandom_range(0, 65535));
      tx_buf[0] = 8'h02; tx_buf[1] = 8'(base / 256); tx_buf[2] = 8'(base % 256);
      for (int k = 3; k < 35; k++) tx_buf[k] = 8'($urandom);
      do_txn(35, "margin_wr");
      half = 4;
      tx_buf[0] = 8'h03;
      for (int k = 3; k < 35; k++) tx_buf[k] = 8'($urandom);
      do_txn(35, "margin_rd");
      host_chk((base + 5) % DEPTH, "margin_host");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
